// File: rtl/rv32i_mem_ctrl.sv
// RV32I memory-stage load/store controller: lane steering, load extension, ack timeout.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned requests trap in IDLE instead of accessing memory.
module rv32i_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_stall,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_err,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we, r_unsigned, r_err;
  logic [1:0]    r_size;
  logic [31:0]   r_addr, r_wdata, r_rdata;

  logic          w_access;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_timeout;

  function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   f_be = 4'b0001 << a;
      2'b01:   f_be = a[1] ? 4'b1100 : 4'b0011;
      default: f_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   f_wdata = {4{d[7:0]}};
      2'b01:   f_wdata = {2{d[15:0]}};
      default: f_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [1:0] sz, input logic [1:0] a,
                                         input logic uns, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'b00:   b = rd[7:0];
      2'b01:   b = rd[15:8];
      2'b10:   b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'b00:   f_load = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   f_load = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: f_load = rd;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = (i_req_size == 2'b01) ? i_req_addr[0]
                    : (i_req_size[1] && (i_req_addr[1:0] != 2'b00));
`endif

  assign w_access  = (r_state == ACCESS);
  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_timeout = (w_cnt_nxt == CW'(TIMEOUT_CYCLES));

  // IDLE stall term is gated by reset so every output reads 0 while held in reset.
  assign o_stall      = w_access | ((r_state == IDLE) & i_req_valid & i_reset);
  assign o_rsp_valid  = (r_state == DONE);
  assign o_rsp_rdata  = r_rdata;
  assign o_err        = r_err;
  assign o_dmem_req   = w_access;
  assign o_dmem_we    = w_access & r_we;
  assign o_dmem_addr  = w_access ? {r_addr[31:2], 2'b00} : 32'h0;
  assign o_dmem_be    = w_access ? f_be(r_size, r_addr[1:0]) : 4'h0;
  assign o_dmem_wdata = w_access ? f_wdata(r_size, r_wdata) : 32'h0;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_req_valid) begin
          r_we       <= i_req_we;
          r_size     <= i_req_size;
          r_unsigned <= i_req_unsigned;
          r_addr     <= i_req_addr;
          r_wdata    <= i_req_wdata;
          r_cnt      <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
          if (w_misalign) begin
            r_state <= DONE;
            r_err   <= 1'b1;
            r_rdata <= 32'h0;
          end else begin
            r_state <= ACCESS;
          end
`else
          r_state <= ACCESS;
`endif
        end
        ACCESS: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (i_dmem_ack) begin
            r_state <= DONE;
            r_err   <= 1'b0;
            r_rdata <= r_we ? 32'h0 : f_load(r_size, r_addr[1:0], r_unsigned, i_dmem_rdata);
          end else if (w_timeout) begin
            r_state <= DONE;
            r_err   <= 1'b1;
            r_rdata <= 32'h0;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_err   <= 1'b0;
          r_rdata <= 32'h0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/rv32i_mem_ctrl.md
RV32I_MEM_CTRL -- requirements
Module: rv32i_mem_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: max cycles waiting for dmem_ack before abort (1..255).
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 req_valid  input  1  memory-stage instruction is a load/store.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-008 req_addr  input  32  byte address (ALU result).
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 stall  output  1  holds upstream pipeline while access is in flight.
REQ-011 rsp_valid  output  1  one-cycle pulse: access complete.
REQ-012 rsp_rdata  output  32  extended load data, valid with rsp_valid.
REQ-013 err  output  1  one-cycle pulse with rsp_valid on timeout or misalign trap.
REQ-014 dmem_req, dmem_we  output  1 each  memory request / write strobe.
REQ-015 dmem_addr  output  32  word-aligned address (bits[1:0]=00).
REQ-016 dmem_be  output  4  byte-lane enables.
REQ-017 dmem_wdata  output  32  store data replicated to lanes.
REQ-018 dmem_ack  input  1  memory completion; dmem_rdata  input  32  read word.

Function
REQ-019 FSM states IDLE, ACCESS, DONE SHALL be used; IDLE on reset.
REQ-020 IDLE with req_valid=1: latch we/size/unsigned/addr/wdata, go ACCESS next edge; stall=1 combinationally that cycle.
REQ-021 ACCESS: dmem_req=1, stall=1, dmem_* driven from latched values, stable until exit.
REQ-022 ACCESS with dmem_ack=1: capture extended load data (0 for stores), go DONE.
REQ-023 ACCESS: cycle counter increments per cycle without ack; on reaching TIMEOUT_CYCLES go DONE with rsp_rdata=0 and err=1.
REQ-024 Ack in same cycle as timeout expiry: ack wins, err=0.
REQ-025 DONE: rsp_valid=1, stall=0, dmem_req=0, return to IDLE next edge (minimum 3-cycle access: IDLE, ACCESS, DONE).
REQ-026 dmem_ack in IDLE or DONE SHALL be ignored.
REQ-027 dmem_be: byte = 1<<addr[1:0]; half = 0011 if addr[1]=0 else 1100; word = 1111.
REQ-028 dmem_wdata: byte replicated x4, half replicated x2, word as is.
REQ-029 Load extract: byte lane addr[1:0], half lane addr[1]; extend to 32 bits per req_unsigned.
REQ-030 Misaligned = half with addr[0]=1, or word with addr[1:0]!=00.
REQ-031 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1); cleared on entry to ACCESS.

Reset
REQ-032 reset=0 SHALL asynchronously force IDLE, counter 0, latched fields 0.
REQ-033 During reset all outputs SHALL be 0, including stall, dmem_req, rsp_valid, err.
REQ-034 Reset mid-ACCESS SHALL drop dmem_req immediately; no rsp_valid issued for the aborted access.

Configuration
REQ-035 Macro MEM_MISALIGN_TRAP_EN defined: misaligned request in IDLE goes directly to DONE (no dmem_req), err=1, rsp_rdata=0.
REQ-036 MEM_MISALIGN_TRAP_EN undefined: misaligned requests proceed normally with byte lanes computed from addr[1:0] per REQ-027/029 and address bits forced aligned; err only on timeout.

Verification
REQ-037 Load word addr 0x100, ack after 2 cycles, rdata 0xDEADBEEF -> dmem_addr 0x100, be 1111, rsp_rdata 0xDEADBEEF, stall high for 4 cycles.
REQ-038 Signed byte load addr 0x203, rdata 0x80000000 -> be 1000, rsp_rdata 0xFFFFFF80; same with req_unsigned=1 -> 0x00000080.
REQ-039 Store half addr 0x302, wdata 0x0000ABCD -> dmem_we 1, be 1100, dmem_wdata 0xABCDABCD, dmem_addr 0x300.
REQ-040 No ack, TIMEOUT_CYCLES=4 -> after 4 ACCESS cycles rsp_valid=1, err=1, rsp_rdata 0; ack arriving on 4th cycle -> err=0.
REQ-041 Word load addr 0x101 with MEM_MISALIGN_TRAP_EN -> no dmem_req, err pulse next cycle; without macro -> normal access at 0x100.
REQ-042 reset=0 asserted during ACCESS -> dmem_req and stall 0 in same cycle, no rsp_valid, next request serviced normally after release.
